// File: rtl/weight_load_ctrl_pkg.sv
// Shared types for the LOAD_WEIGHT sequencer: FSM states, weight-row index type, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package weight_load_ctrl_pkg;

  // Default systolic array dimension (weight rows per tile).
  localparam int unsigned MATRIX_WIDTH_DEF = 8;

  typedef logic [$clog2(MATRIX_WIDTH_DEF)-1:0] weight_row_t;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_RUN,
    WL_DRAIN,
    WL_FIN
  } wl_state_t;

  // Width of a counter that must hold 0..n-1; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Instruction channel between the decoder (master) and the weight-load sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready; a transfer happens when valid, ready and the global enable are all high.
// Signals: instr_valid/instr_ready handshake, instr_addr base address, instr_len row count,
//          instr_signed weight signedness.
interface weight_load_ctrl_if #(
  parameter int BUF_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 32
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [BUF_ADDR_WIDTH-1:0] instr_addr;
  logic [LEN_WIDTH-1:0]      instr_len;
  logic                      instr_signed;

  modport master (
    output instr_valid, instr_addr, instr_len, instr_signed,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_addr, instr_len, instr_signed,
    output instr_ready
  );
endinterface

// File: rtl/weight_load_ctrl_delay_line.sv
// Enable-gated shift register aligning the read strobe/row with the weight-buffer return data.
// Latency: DEPTH enabled cycles from in_dat to out_dat.
// Backpressure: enable=0 holds every stage, so nothing is lost or duplicated across a stall.
// Ports: clk, rst (sync, active-high, clears all stages), enable, in_dat, out_dat.
module weight_load_ctrl_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_dat,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] sh_q [DEPTH];
  logic [WIDTH-1:0] sh_d [DEPTH];

  always_comb begin
    sh_d = sh_q;
    if (enable) begin
      sh_d[0] = in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        sh_d[i] = sh_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      sh_q <= sh_d;
    end
  end

  assign out_dat = sh_q[DEPTH-1];

endmodule

// File: rtl/weight_load_ctrl.sv
// Executes one LOAD_WEIGHT: len buffer reads from addr, each returned row written to the array.
// Latency: first read 1 cycle after accept, first write BUF_LATENCY later, done 1 after last write.
// Backpressure: instr_ready only in IDLE; enable=0 freezes all state and masks every strobe.
// Ports: clk, rst (sync, active-high), enable, instr (slave instruction channel),
//        buf_en/buf_addr (buffer reads), weight_we/weight_row (array writes),
//        weight_signed, busy, done (one-cycle completion pulse).
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int MATRIX_WIDTH   = MATRIX_WIDTH_DEF,
  parameter int BUF_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 32,
  parameter int BUF_LATENCY    = 2,
  localparam int ROW_W         = cnt_width(MATRIX_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  weight_load_ctrl_if.slave         instr,
  output logic                      buf_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  output logic                      weight_we,
  output logic [ROW_W-1:0]          weight_row,
  output logic                      weight_signed,
  output logic                      busy,
  output logic                      done
);

  localparam int DRAIN_W = cnt_width(BUF_LATENCY);
  localparam logic [BUF_ADDR_WIDTH-1:0] ADDR_ONE   = BUF_ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]      LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [ROW_W-1:0]          ROW_ONE    = ROW_W'(1);
  localparam logic [ROW_W-1:0]          ROW_LAST   = ROW_W'(MATRIX_WIDTH - 1);
  localparam logic [DRAIN_W-1:0]        DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0]        DRAIN_LAST = DRAIN_W'(BUF_LATENCY - 1);

  wl_state_t                 state_q, state_d;
  logic [BUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic                      sgn_q, sgn_d;

  logic                      ready;
  logic                      accept;
  logic                      issue;
  logic                      last_issue;
  logic                      dl_we;
  logic [ROW_W-1:0]          dl_row;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    drain_d = drain_q;
    sgn_d   = sgn_q;

    ready  = (state_q == WL_IDLE);
    accept = instr.instr_valid & ready & enable;
    issue  = enable & (state_q == WL_RUN);
    // RUN is only entered with len>0, so len_q-1 never underflows here.
    last_issue = issue & (cnt_q == (len_q - LEN_ONE));

    case (state_q)
      WL_IDLE: begin
        if (accept) begin
          addr_d  = instr.instr_addr;
          len_d   = instr.instr_len;
          cnt_d   = '0;
          row_d   = '0;
          sgn_d   = instr.instr_signed;
          state_d = (instr.instr_len == '0) ? WL_FIN : WL_RUN;
        end
      end
      WL_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q + LEN_ONE;
          row_d  = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
          if (last_issue) begin
            state_d = WL_DRAIN;
            drain_d = '0;
          end
        end
      end
      // Wait for the final read to emerge from the buffer pipeline.
      WL_DRAIN: begin
        if (enable) begin
          if (drain_q == DRAIN_LAST) begin
            state_d = WL_FIN;
          end else begin
            drain_d = drain_q + DRAIN_ONE;
          end
        end
      end
      WL_FIN: begin
        if (enable) begin
          state_d = WL_IDLE;
        end
      end
      default: state_d = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WL_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      sgn_q   <= sgn_d;
    end
  end

  // The strobe and its row travel together so they stay aligned through stalls.
  weight_load_ctrl_delay_line #(
    .WIDTH (1 + ROW_W),
    .DEPTH (BUF_LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .in_dat  ({issue, row_q}),
    .out_dat ({dl_we, dl_row})
  );

  assign instr.instr_ready = ready;
  assign buf_en            = issue;
  assign buf_addr          = addr_q;
  assign weight_we         = enable & dl_we;
  assign weight_row        = dl_row;
  assign weight_signed     = sgn_q;
  assign busy              = (state_q != WL_IDLE);
  assign done              = enable & (state_q == WL_FIN);

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Testbench for weight_load_ctrl: directed cases plus randomized instructions and stalls.
// Latency: n/a.
// Backpressure: n/a.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  localparam int MW  = 8;
  localparam int BAW = 16;
  localparam int LW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic buf_en, weight_we, weight_signed, busy, done;
  logic [BAW-1:0] buf_addr;
  weight_row_t    weight_row;

  always #5 clk = ~clk;

  weight_load_ctrl_if #(.BUF_ADDR_WIDTH(BAW), .LEN_WIDTH(LW)) instr_if ();

  weight_load_ctrl #(
    .MATRIX_WIDTH(MW), .BUF_ADDR_WIDTH(BAW), .LEN_WIDTH(LW), .BUF_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .instr         (instr_if),
    .buf_en        (buf_en),
    .buf_addr      (buf_addr),
    .weight_we     (weight_we),
    .weight_row    (weight_row),
    .weight_signed (weight_signed),
    .busy          (busy),
    .done          (done)
  );

  // Expected events, stamped with the index of the enabled cycle in which they must appear.
  typedef struct { int unsigned idx; logic [BAW-1:0] addr; } rd_t;
  typedef struct { int unsigned idx; int unsigned row; } wr_t;
  typedef struct { int unsigned acc; int unsigned idx; logic sgn; } dn_t;

  rd_t rq[$];
  wr_t wq[$];
  dn_t dq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned ecnt = 0;   // enabled cycles completed
  int unsigned wcnt = 0;   // wall cycles completed
  int unsigned done_wall = 0;
  int unsigned we_total = 0, rd_total = 0, done_total = 0;

  always @(posedge clk) begin
    wcnt <= wcnt + 1;
    if (enable) ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, wcnt);
    end
  endtask

  function automatic logic rnd_en(input int pct);
    return ($urandom_range(99) >= pct);
  endfunction

  // Monitor / scoreboard: samples 3ns after each rising edge.
  initial begin
    rd_t r;
    wr_t w;
    dn_t d;
    logic exp_busy;
    forever begin
      @(posedge clk);
      #3;
      exp_busy = (dq.size() > 0) && (ecnt > dq[0].acc);
      chk("busy", busy, exp_busy);
      chk("instr_ready", instr_if.instr_ready, !exp_busy);
      if (exp_busy) chk("weight_signed", weight_signed, dq[0].sgn);
      if (buf_en) begin
        rd_total++;
        chk("buf_en_only_when_enabled", enable, 1);
        chk("read_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          chk("read_timing", ecnt, r.idx);
          chk("buf_addr", buf_addr, r.addr);
        end
      end
      if (weight_we) begin
        we_total++;
        chk("weight_we_only_when_enabled", enable, 1);
        chk("write_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("write_timing", ecnt, w.idx);
          chk("weight_row", weight_row, w.row);
        end
      end
      if (done) begin
        done_total++;
        done_wall = wcnt;
        chk("done_only_when_enabled", enable, 1);
        chk("done_expected", dq.size() > 0, 1);
        if (dq.size() > 0) begin
          d = dq.pop_front();
          chk("done_timing", ecnt, d.idx);
        end
      end
    end
  end

  // Present an instruction, wait for acceptance, record expected behaviour.
  // Returns at 1ns into the cycle after the accept edge.
  task automatic issue(input logic [BAW-1:0] a, input int unsigned l, input logic s,
                       input int hold, input int pct, output int unsigned acc_wall);
    int guard = 0;
    bit got = 0;
    int unsigned acc;
    logic [BAW-1:0] ad;
    acc_wall = 0;
    instr_if.instr_valid  = 1'b1;
    instr_if.instr_addr   = a;
    instr_if.instr_len    = l;
    instr_if.instr_signed = s;
    while (!got && guard < 400) begin
      @(negedge clk);
      if (instr_if.instr_ready && enable && !rst) begin
        got = 1;
        acc = ecnt;
        acc_wall = wcnt;
        ad = a;
        for (int unsigned i = 0; i < l; i++) begin
          rq.push_back('{idx: acc + 1 + i, addr: ad});
          wq.push_back('{idx: acc + 1 + i + LAT, row: i % MW});
          ad = ad + 1'b1;
        end
        dq.push_back('{acc: acc, idx: (l == 0) ? acc + 1 : acc + l + LAT + 1, sgn: s});
      end
      @(posedge clk);
      #1;
      enable = rnd_en(pct);
      guard++;
    end
    chk("accept_within_budget", got, 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      enable = rnd_en(pct);
    end
    instr_if.instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int pct);
    int g = 0;
    while ((rq.size() + wq.size() + dq.size()) != 0 && g < 600) begin
      @(posedge clk);
      #1;
      enable = rnd_en(pct);
      g++;
    end
    chk("drain_within_budget", rq.size() + wq.size() + dq.size(), 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_buf_en"}, buf_en, 0);
    chk({tag, "_weight_we"}, weight_we, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_weight_signed"}, weight_signed, 0);
    chk({tag, "_buf_addr"}, buf_addr, 0);
    chk({tag, "_weight_row"}, weight_row, 0);
    chk({tag, "_instr_ready"}, instr_if.instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned aw, we0, rd0, dn0, sum_len, l;
    rst = 1'b1;
    enable = 1'b1;
    instr_if.instr_valid  = 1'b0;
    instr_if.instr_addr   = '0;
    instr_if.instr_len    = '0;
    instr_if.instr_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic load, valid held high for several busy cycles.
    we0 = we_total; rd0 = rd_total;
    issue(16'h0010, 8, 1'b1, 3, 0, aw);
    wait_idle(0);
    chk("len8_done_cycle", done_wall - aw, 11);
    chk("len8_writes", we_total - we0, 8);
    chk("len8_reads", rd_total - rd0, 8);

    // Row index wraps twice.
    we0 = we_total; dn0 = done_total;
    issue(16'h0100, 20, 1'b0, 0, 0, aw);
    wait_idle(0);
    chk("len20_writes", we_total - we0, 20);
    chk("len20_single_done", done_total - dn0, 1);

    // Three-cycle stall starting at T+4.
    we0 = we_total; rd0 = rd_total;
    issue(16'h0200, 8, 1'b0, 0, 0, aw);
    repeat (3) begin @(posedge clk); #1; end
    enable = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    enable = 1'b1;
    wait_idle(0);
    chk("stall_done_cycle", done_wall - aw, 14);
    chk("stall_writes", we_total - we0, 8);
    chk("stall_reads", rd_total - rd0, 8);

    // Address wrap-around.
    issue(16'hFFFE, 4, 1'b1, 0, 0, aw);
    wait_idle(0);

    // Zero length, valid held through the busy cycle.
    we0 = we_total; rd0 = rd_total; dn0 = done_total;
    issue(16'h1234, 0, 1'b1, 1, 0, aw);
    wait_idle(0);
    chk("len0_done_cycle", done_wall - aw, 1);
    chk("len0_no_writes", we_total - we0, 0);
    chk("len0_no_reads", rd_total - rd0, 0);
    chk("len0_single_done", done_total - dn0, 1);

    // Reset in the middle of a load aborts it without done.
    issue(16'h0300, 8, 1'b1, 0, 0, aw);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    rq.delete();
    wq.delete();
    dq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    dn0 = done_total;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_done", done_total - dn0, 0);

    // Randomized instructions with random stalls and back-to-back issue.
    we0 = we_total;
    sum_len = 0;
    for (int k = 0; k < 40; k++) begin
      l = $urandom_range(20);
      sum_len += l;
      issue(BAW'($urandom), l, 1'($urandom), $urandom_range(l + 1), 25, aw);
      if ($urandom_range(3) == 0) wait_idle(25);
    end
    wait_idle(25);
    chk("random_total_writes", we_total - we0, sum_len);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
